config_queue_manager: RTL and testbench

- Next-generation layer configuration manager for the FlexPipe core.
- Host writes configuration fields by address over an AXI-lite write channel into a staging register set, then commits the staged set into a parametrised FIFO of pending layer configurations.
- Pops the head entry into the active configuration through the existing request_flip/flip_ack handshake with the core, so several layers can be queued ahead of execution.
- Adds epoch tracking, overflow error reporting and a host-driven flush.

---
 rtl/config_queue_manager_if.sv | 26 ++
 rtl/config_queue_manager.sv | 200 ++++++++++++++++++++
 tb/tb_config_queue_manager.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_queue_manager_if.sv
// AXI-lite write channel between the host and the configuration queue manager.
// The host side uses the master modport and the queue manager uses the slave modport.
interface config_queue_manager_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/config_queue_manager.sv
// Layer configuration manager for the FlexPipe core.
// The host fills a staging register set over AXI-lite and commits it into a FIFO
// of pending layer configurations. The head of the FIFO becomes the active
// configuration through the request_flip / flip_ack handshake with the core.
// Also tracks an epoch (completed flips), a sticky overflow error and a host flush.
module config_queue_manager #(
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_FIELDS  = 4,
  parameter int FIELD_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int EPOCH_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  config_queue_manager_if.slave             s_axi,
  input  logic                              core_safe_to_flip,
  input  logic                              no_outstanding_active,
  output logic                              request_flip,
  input  logic                              flip_ack,
  output logic [NUM_FIELDS*FIELD_WIDTH-1:0] active_cfg,
  output logic                              active_valid,
  output logic                              layer_start_pulse,
  output logic [EPOCH_WIDTH-1:0]            current_epoch,
  output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
  output logic                              queue_full,
  output logic                              overflow_err
);

  localparam int IDX_W       = ADDR_WIDTH - 2;
  localparam int PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int CFG_W       = NUM_FIELDS * FIELD_WIDTH;
  localparam int FIELD_BYTES = FIELD_WIDTH / 8;

  localparam logic [IDX_W-1:0] COMMIT_IDX = IDX_W'(NUM_FIELDS);
  localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(NUM_FIELDS + 1);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE,
    RESP
  } axi_state_t;

  axi_state_t       axi_state;
  logic [CFG_W-1:0] staging;
  logic [CFG_W-1:0] fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [IDX_W-1:0] wr_idx;
  logic             wr_accept;
  logic             is_field;
  logic             is_commit;
  logic             is_ctrl;
  logic             push;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic             commit_reject;
  logic             unused_addr_bits;

  // Address bits [1:0] only select a byte within a word and carry no meaning here.
  assign unused_addr_bits = ^s_axi.awaddr[1:0];

  assign wr_idx        = s_axi.awaddr[ADDR_WIDTH-1:2];
  assign wr_accept     = (axi_state == IDLE) && s_axi.awvalid && s_axi.wvalid;
  assign is_field      = wr_idx < COMMIT_IDX;
  assign is_commit     = wr_idx == COMMIT_IDX;
  assign is_ctrl       = wr_idx == CTRL_IDX;
  assign queue_full    = queue_count == CNT_W'(QUEUE_DEPTH);
  // The full test uses the count before any same-cycle pop, so a commit to a
  // full queue is rejected even if the core frees a slot on that very edge.
  assign push          = wr_accept && is_commit && !queue_full;
  assign commit_reject = wr_accept && is_commit && queue_full;
  assign pop           = request_flip && flip_ack;
  assign flush         = wr_accept && is_ctrl && s_axi.wdata[1];
  assign clear_err     = wr_accept && is_ctrl && s_axi.wdata[0];

  // AXI write FSM: accept a write when address and data arrive together, then hold the response until bready.
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_state     <= IDLE;
      s_axi.awready <= 1'b1;
      s_axi.wready  <= 1'b1;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
    end else begin
      case (axi_state)
        IDLE: begin
          if (wr_accept) begin
            axi_state     <= RESP;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b1;
            if (commit_reject || !(is_field || is_commit || is_ctrl)) begin
              s_axi.bresp <= RESP_SLVERR;
            end else begin
              s_axi.bresp <= RESP_OKAY;
            end
          end
        end
        RESP: begin
          if (s_axi.bready) begin
            axi_state     <= IDLE;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            s_axi.bvalid  <= 1'b0;
          end
        end
        default: begin
          axi_state <= IDLE;
        end
      endcase
    end
  end

  // Staging registers: byte-strobed field writes; lanes beyond the field width are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging <= '0;
    end else if (wr_accept && is_field) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        for (int b = 0; b < FIELD_BYTES; b++) begin
          if ((wr_idx == IDX_W'(f)) && s_axi.wstrb[b]) begin
            staging[f*FIELD_WIDTH + b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // FIFO storage: a commit copies the whole staging set into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= staging;
    end
  end

  // FIFO pointers and occupancy; a flush discards everything left after any same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  // Flip handshake: request when the core is idle at a boundary, then load the head as active on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      request_flip      <= 1'b0;
      active_cfg        <= '0;
      active_valid      <= 1'b0;
      layer_start_pulse <= 1'b0;
      current_epoch     <= '0;
    end else begin
      layer_start_pulse <= pop;
      if (pop) begin
        active_cfg    <= fifo_mem[rd_ptr];
        active_valid  <= 1'b1;
        current_epoch <= current_epoch + 1'b1;
      end
      if (flush || pop) begin
        request_flip <= 1'b0;
      end else if (!request_flip && (queue_count != '0) &&
                   core_safe_to_flip && no_outstanding_active) begin
        request_flip <= 1'b1;
      end
    end
  end

  // Sticky overflow flag: set by a rejected commit, cleared only by the host through CTRL.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (commit_reject) begin
      overflow_err <= 1'b1;
    end else if (clear_err) begin
      overflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_queue_manager.sv
// Self-checking bench for config_queue_manager.
// Every clock is mirrored by a queue-based reference model and all outputs are
// compared after each edge; directed tables and sequences add fixed expectations.
module tb_config_queue_manager;

  localparam int ADDR_WIDTH  = 12;
  localparam int NUM_FIELDS  = 4;
  localparam int FIELD_WIDTH = 32;
  localparam int QUEUE_DEPTH = 4;
  localparam int EPOCH_WIDTH = 8;
  localparam int CFG_W       = NUM_FIELDS * FIELD_WIDTH;
  localparam int CTRL_IDX    = NUM_FIELDS + 1;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         core_safe_to_flip;
  logic                         no_outstanding_active;
  logic                         request_flip;
  logic                         flip_ack;
  logic [CFG_W-1:0]             active_cfg;
  logic                         active_valid;
  logic                         layer_start_pulse;
  logic [EPOCH_WIDTH-1:0]       current_epoch;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;
  logic                         queue_full;
  logic                         overflow_err;

  config_queue_manager_if #(.ADDR_WIDTH(ADDR_WIDTH)) axi ();

  config_queue_manager #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_WIDTH(FIELD_WIDTH),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .EPOCH_WIDTH(EPOCH_WIDTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axi                (axi),
    .core_safe_to_flip    (core_safe_to_flip),
    .no_outstanding_active(no_outstanding_active),
    .request_flip         (request_flip),
    .flip_ack             (flip_ack),
    .active_cfg           (active_cfg),
    .active_valid         (active_valid),
    .layer_start_pulse    (layer_start_pulse),
    .current_epoch        (current_epoch),
    .queue_count          (queue_count),
    .queue_full           (queue_full),
    .overflow_err         (overflow_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit               m_resp;
  logic [1:0]       m_bresp;
  logic [31:0]      m_field [NUM_FIELDS];
  logic [CFG_W-1:0] m_queue [$];
  logic [CFG_W-1:0] m_active;
  bit               m_active_valid;
  bit               m_req;
  bit               m_pulse;
  bit               m_ovf;
  int               m_epoch;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    int          exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [CFG_W-1:0] actual,
                             input logic [CFG_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [CFG_W-1:0] packStaging();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int f = 0; f < NUM_FIELDS; f++) v[f*FIELD_WIDTH +: FIELD_WIDTH] = m_field[f];
    return v;
  endfunction

  task automatic modelReset();
    m_resp = 0;
    m_bresp = 2'b00;
    for (int f = 0; f < NUM_FIELDS; f++) m_field[f] = '0;
    m_queue.delete();
    m_active = '0;
    m_active_valid = 0;
    m_req = 0;
    m_pulse = 0;
    m_ovf = 0;
    m_epoch = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    int  idx;
    int  size_before;
    bit  accept;
    bit  pop;
    bit  flush;
    bit  next_req;
    if (rst) begin
      modelReset();
      return;
    end
    size_before = m_queue.size();
    accept = !m_resp && axi.awvalid && axi.wvalid;
    idx = int'(axi.awaddr >> 2);
    pop = m_req && flip_ack;
    flush = accept && (idx == CTRL_IDX) && axi.wdata[1];
    if (flush || pop) next_req = 0;
    else if (!m_req && size_before > 0 && core_safe_to_flip && no_outstanding_active) next_req = 1;
    else next_req = m_req;
    m_pulse = pop;
    if (pop) begin
      m_active = m_queue.pop_front();
      m_active_valid = 1;
      m_epoch = (m_epoch + 1) % (1 << EPOCH_WIDTH);
    end
    if (m_resp) begin
      if (axi.bready) m_resp = 0;
    end else if (accept) begin
      m_resp = 1;
      m_bresp = 2'b00;
      if (idx < NUM_FIELDS) begin
        for (int b = 0; b < FIELD_WIDTH / 8; b++)
          if (axi.wstrb[b]) m_field[idx][8*b +: 8] = axi.wdata[8*b +: 8];
      end else if (idx == NUM_FIELDS) begin
        if (size_before == QUEUE_DEPTH) begin
          m_ovf = 1;
          m_bresp = 2'b10;
        end else begin
          m_queue.push_back(packStaging());
        end
      end else if (idx == CTRL_IDX) begin
        if (axi.wdata[0]) m_ovf = 0;
        if (axi.wdata[1]) m_queue.delete();
      end else begin
        m_bresp = 2'b10;
      end
    end
    m_req = next_req;
  endtask

  task automatic compareAll();
    checkOutput("awready", CFG_W'(axi.awready), CFG_W'(!m_resp));
    checkOutput("wready", CFG_W'(axi.wready), CFG_W'(!m_resp));
    checkOutput("bvalid", CFG_W'(axi.bvalid), CFG_W'(m_resp));
    if (m_resp) checkOutput("bresp", CFG_W'(axi.bresp), CFG_W'(m_bresp));
    checkOutput("request_flip", CFG_W'(request_flip), CFG_W'(m_req));
    checkOutput("active_cfg", active_cfg, m_active);
    checkOutput("active_valid", CFG_W'(active_valid), CFG_W'(m_active_valid));
    checkOutput("layer_start_pulse", CFG_W'(layer_start_pulse), CFG_W'(m_pulse));
    checkOutput("current_epoch", CFG_W'(current_epoch), CFG_W'(m_epoch));
    checkOutput("queue_count", CFG_W'(queue_count), CFG_W'(m_queue.size()));
    checkOutput("queue_full", CFG_W'(queue_full), CFG_W'(m_queue.size() == QUEUE_DEPTH));
    checkOutput("overflow_err", CFG_W'(overflow_err), CFG_W'(m_ovf));
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  // One complete AXI write: wait for ready, present, then take the response with bready high.
  task automatic applyStimulus(input int idx, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp);
    int guard;
    axi.awaddr = ADDR_WIDTH'(idx * 4);
    axi.wdata = data;
    axi.wstrb = strb;
    axi.bready = 1'b1;
    guard = 0;
    while (axi.awready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (axi.awready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL awready_timeout: awready=%b, expected 1", axi.awready);
    end
    axi.awvalid = 1'b1;
    axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    resp = axi.bresp;
    tick();
  endtask

  task automatic waitFlipRequest();
    int guard;
    guard = 0;
    while (request_flip !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("flip_request_seen", CFG_W'(request_flip), CFG_W'(1));
  endtask

  task automatic doFlip();
    waitFlipRequest();
    tick();
    flip_ack = 1'b1;
    tick();
    checkOutput("flip_pulse_high", CFG_W'(layer_start_pulse), CFG_W'(1));
    flip_ack = 1'b0;
    tick();
    checkOutput("flip_pulse_low", CFG_W'(layer_start_pulse), CFG_W'(0));
  endtask

  initial begin
    logic [1:0] resp;

    rst = 1'b1;
    core_safe_to_flip = 1'b0;
    no_outstanding_active = 1'b1;
    flip_ack = 1'b0;
    axi.awaddr = '0;
    axi.awvalid = 1'b0;
    axi.wdata = '0;
    axi.wstrb = '0;
    axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    modelReset();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_awready", CFG_W'(axi.awready), CFG_W'(1));
    checkOutput("reset_bvalid", CFG_W'(axi.bvalid), CFG_W'(0));
    checkOutput("reset_epoch", CFG_W'(current_epoch), CFG_W'(0));
    checkOutput("reset_count", CFG_W'(queue_count), CFG_W'(0));

    // Basic commit and flip
    core_safe_to_flip = 1'b1;
    applyStimulus(0, 32'h11, 4'hF, resp);
    applyStimulus(1, 32'h22, 4'hF, resp);
    applyStimulus(2, 32'h33, 4'hF, resp);
    applyStimulus(3, 32'h44, 4'hF, resp);
    applyStimulus(NUM_FIELDS, 32'h0, 4'hF, resp);
    checkOutput("commit_resp", CFG_W'(resp), CFG_W'(2'b00));
    doFlip();
    checkOutput("t1_active_cfg", active_cfg, {32'h44, 32'h33, 32'h22, 32'h11});
    checkOutput("t1_epoch", CFG_W'(current_epoch), CFG_W'(1));
    checkOutput("t1_count", CFG_W'(queue_count), CFG_W'(0));

    // Address map table: overflow, error clear, bad indexes, flush, strobed field write
    core_safe_to_flip = 1'b0;
    vecs[0]  = '{NUM_FIELDS, 32'h0,         4'hF, 2'b00, 1, 1'b0};
    vecs[1]  = '{NUM_FIELDS, 32'h0,         4'hF, 2'b00, 2, 1'b0};
    vecs[2]  = '{NUM_FIELDS, 32'h0,         4'hF, 2'b00, 3, 1'b0};
    vecs[3]  = '{NUM_FIELDS, 32'h0,         4'hF, 2'b00, 4, 1'b0};
    vecs[4]  = '{NUM_FIELDS, 32'h0,         4'hF, 2'b10, 4, 1'b1};
    vecs[5]  = '{CTRL_IDX,   32'h1,         4'hF, 2'b00, 4, 1'b0};
    vecs[6]  = '{9,          32'hFFFF_FFFF, 4'hF, 2'b10, 4, 1'b0};
    vecs[7]  = '{7,          32'hFFFF_FFFF, 4'hF, 2'b10, 4, 1'b0};
    vecs[8]  = '{CTRL_IDX,   32'h2,         4'hF, 2'b00, 0, 1'b0};
    vecs[9]  = '{2,          32'h0,         4'hF, 2'b00, 0, 1'b0};
    vecs[10] = '{2,          32'hAABB_CCDD, 4'h2, 2'b00, 0, 1'b0};
    vecs[11] = '{NUM_FIELDS, 32'h0,         4'hF, 2'b00, 1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].data, vecs[i].strb, resp);
      checkOutput($sformatf("vec%0d_bresp", i), CFG_W'(resp), CFG_W'(vecs[i].exp_resp));
      checkOutput($sformatf("vec%0d_count", i), CFG_W'(queue_count), CFG_W'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_full", i), CFG_W'(queue_full),
                  CFG_W'(vecs[i].exp_count == QUEUE_DEPTH));
      checkOutput($sformatf("vec%0d_ovf", i), CFG_W'(overflow_err), CFG_W'(vecs[i].exp_ovf));
    end
    core_safe_to_flip = 1'b1;
    doFlip();
    checkOutput("t3_active_cfg", active_cfg, {32'h44, 32'h0000_CC00, 32'h22, 32'h11});
    checkOutput("t3_epoch", CFG_W'(current_epoch), CFG_W'(2));

    // Response back-pressure: a second write waits for the bready handshake
    axi.awaddr = ADDR_WIDTH'(0);
    axi.wdata = 32'h5555_0000;
    axi.wstrb = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid = 1'b1;
    axi.bready = 1'b0;
    tick();
    axi.wdata = 32'h0000_00A5;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_bvalid", CFG_W'(axi.bvalid), CFG_W'(1));
      checkOutput("bp_bresp", CFG_W'(axi.bresp), CFG_W'(2'b00));
      checkOutput("bp_awready", CFG_W'(axi.awready), CFG_W'(0));
      checkOutput("bp_wready", CFG_W'(axi.wready), CFG_W'(0));
    end
    axi.bready = 1'b1;
    tick();
    checkOutput("bp_released", CFG_W'(axi.awready), CFG_W'(1));
    tick();
    checkOutput("bp_second_accepted", CFG_W'(axi.bvalid), CFG_W'(1));
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    tick();

    // Flush coinciding with flip_ack: the head flips, the rest is discarded
    core_safe_to_flip = 1'b0;
    applyStimulus(0, 32'hA1, 4'hF, resp);
    applyStimulus(NUM_FIELDS, 32'h0, 4'hF, resp);
    applyStimulus(0, 32'hA2, 4'hF, resp);
    applyStimulus(NUM_FIELDS, 32'h0, 4'hF, resp);
    checkOutput("t5_count2", CFG_W'(queue_count), CFG_W'(2));
    core_safe_to_flip = 1'b1;
    waitFlipRequest();
    flip_ack = 1'b1;
    axi.awaddr = ADDR_WIDTH'(CTRL_IDX * 4);
    axi.wdata = 32'h2;
    axi.awvalid = 1'b1;
    axi.wvalid = 1'b1;
    tick();
    flip_ack = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    checkOutput("t5_active_cfg", active_cfg, {32'h44, 32'h0000_CC00, 32'h22, 32'hA1});
    checkOutput("t5_epoch", CFG_W'(current_epoch), CFG_W'(3));
    checkOutput("t5_count", CFG_W'(queue_count), CFG_W'(0));
    checkOutput("t5_request", CFG_W'(request_flip), CFG_W'(0));
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t5_no_second_flip", CFG_W'(current_epoch), CFG_W'(3));
    checkOutput("t5_request_idle", CFG_W'(request_flip), CFG_W'(0));

    // Reset while a flip request and a write response are both pending
    core_safe_to_flip = 1'b0;
    applyStimulus(NUM_FIELDS, 32'h0, 4'hF, resp);
    core_safe_to_flip = 1'b1;
    waitFlipRequest();
    axi.awaddr = ADDR_WIDTH'(4);
    axi.wdata = 32'h1234_5678;
    axi.awvalid = 1'b1;
    axi.wvalid = 1'b1;
    axi.bready = 1'b0;
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    checkOutput("t6_bvalid_before", CFG_W'(axi.bvalid), CFG_W'(1));
    checkOutput("t6_request_before", CFG_W'(request_flip), CFG_W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    axi.bready = 1'b1;
    checkOutput("t6_request", CFG_W'(request_flip), CFG_W'(0));
    checkOutput("t6_bvalid", CFG_W'(axi.bvalid), CFG_W'(0));
    checkOutput("t6_awready", CFG_W'(axi.awready), CFG_W'(1));
    checkOutput("t6_count", CFG_W'(queue_count), CFG_W'(0));
    checkOutput("t6_epoch", CFG_W'(current_epoch), CFG_W'(0));
    checkOutput("t6_active_cfg", active_cfg, '0);
    checkOutput("t6_active_valid", CFG_W'(active_valid), CFG_W'(0));

    // Randomized traffic against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
      rst = ($urandom_range(0, 149) == 0);
      axi.awvalid = $urandom_range(0, 1) == 1;
      axi.wvalid = $urandom_range(0, 2) != 0;
      axi.awaddr = ADDR_WIDTH'({$urandom_range(0, 7), 2'($urandom_range(0, 3))});
      axi.wdata = d;
      axi.wstrb = 4'($urandom);
      axi.bready = $urandom_range(0, 3) != 0;
      core_safe_to_flip = $urandom_range(0, 3) != 0;
      no_outstanding_active = $urandom_range(0, 3) != 0;
      flip_ack = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
